// File: rtl/range_finder_stream.sv
// -----------------------------------------------------------------------------
// range_finder_stream
//   Framed min/max/range tracker over a valid-qualified sample stream.
//   A frame opens on a go sample and closes on a finish sample. The last
//   completed frame's min, max, range, count and (optionally) sum are held in
//   result registers, and done pulses for one cycle when they update.
//   Protocol violations and counter overflow park the block in ERROR until the
//   next clean go sample arrives.
//
// Optional feature macro: RANGE_FINDER_SUM_EN
//   defined   -> per-frame accumulator; sum output carries the frame total
//   undefined -> no accumulator; sum is tied to 0
//
// Parameters
//   WIDTH   sample/result width
//   CNT_W   sample counter width (frame holds at most 2**CNT_W-1 samples)
//   SIGNED  0: unsigned compare, 1: two's-complement compare
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous active-high reset
//   data_in      sample
//   data_valid   qualifies data_in, go and finish
//   go           first sample of a frame
//   finish       last sample of a frame
//   range        max-min of last completed frame (unsigned)
//   min_out      minimum of last completed frame
//   max_out      maximum of last completed frame
//   count        sample count of last completed frame
//   sum          sum of last completed frame's samples
//   done         one-cycle pulse when results update
//   busy         high while a frame is open (RUN)
//   error        high while in ERROR
// -----------------------------------------------------------------------------
module range_finder_stream #(
   parameter int WIDTH  = 8,
   parameter int CNT_W  = 8,
   parameter int SIGNED = 0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       data_in,
   input  logic                   data_valid,
   input  logic                   go,
   input  logic                   finish,
   output logic [WIDTH-1:0]       range,
   output logic [WIDTH-1:0]       min_out,
   output logic [WIDTH-1:0]       max_out,
   output logic [CNT_W-1:0]       count,
   output logic [WIDTH+CNT_W-1:0] sum,
   output logic                   done,
   output logic                   busy,
   output logic                   error
);

   typedef enum logic [1:0] {IDLE, RUN, ERROR} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_reg;
   logic [WIDTH-1:0] min_reg, max_reg;
   logic [CNT_W-1:0] cnt_reg;

   logic [WIDTH-1:0] min_next, max_next;
   logic [CNT_W-1:0] cnt_next;
   logic             start_frame, single_frame, accept, complete, to_error;

   function automatic logic less_than(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      if (SIGNED != 0) return $signed(a) < $signed(b);
      else             return a < b;
   endfunction

   // Event decode: every state change below is driven by exactly one of these.
   always_comb begin
      start_frame  = data_valid && go && !finish && (state_reg == IDLE || state_reg == ERROR);
      single_frame = data_valid && go && finish && (state_reg == IDLE);
      // In RUN, go aborts the frame and a full counter drops the sample.
      accept       = data_valid && (state_reg == RUN) && !go && (cnt_reg != CNT_MAX);
      complete     = accept && finish;
      to_error     = data_valid && (((state_reg == IDLE) && !go && finish) ||
                                    ((state_reg == RUN) && (go || cnt_reg == CNT_MAX)));
      min_next     = less_than(data_in, min_reg) ? data_in : min_reg;
      max_next     = less_than(max_reg, data_in) ? data_in : max_reg;
      cnt_next     = cnt_reg + CNT_ONE;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         min_reg   <= '0;
         max_reg   <= '0;
         cnt_reg   <= '0;
         range     <= '0;
         min_out   <= '0;
         max_out   <= '0;
         count     <= '0;
         done      <= 1'b0;
      end else begin
         done <= complete || single_frame;
         if (start_frame) begin
            state_reg <= RUN;
            min_reg   <= data_in;
            max_reg   <= data_in;
            cnt_reg   <= CNT_ONE;
         end else if (single_frame) begin
            min_out <= data_in;
            max_out <= data_in;
            range   <= '0;
            count   <= CNT_ONE;
         end else if (to_error) begin
            state_reg <= ERROR;
         end else if (accept) begin
            min_reg <= min_next;
            max_reg <= max_next;
            cnt_reg <= cnt_next;
            if (finish) begin
               state_reg <= IDLE;
               min_out   <= min_next;
               max_out   <= max_next;
               // max >= min in the chosen ordering, so the difference never wraps.
               range     <= max_next - min_next;
               count     <= cnt_next;
            end
         end
      end
   end

`ifdef RANGE_FINDER_SUM_EN
   logic [WIDTH+CNT_W-1:0] acc_reg, sum_reg, sample_ext;

   always_comb begin
      if (SIGNED != 0) sample_ext = {{CNT_W{data_in[WIDTH-1]}}, data_in};
      else             sample_ext = {{CNT_W{1'b0}}, data_in};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc_reg <= '0;
         sum_reg <= '0;
      end else if (start_frame) begin
         acc_reg <= sample_ext;
      end else if (single_frame) begin
         sum_reg <= sample_ext;
      end else if (accept) begin
         acc_reg <= acc_reg + sample_ext;
         if (finish) sum_reg <= acc_reg + sample_ext;
      end
   end

   assign sum = sum_reg;
`else
   assign sum = '0;
`endif

   assign busy  = (state_reg == RUN);
   assign error = (state_reg == ERROR);

endmodule

// File: tb/tb_range_finder_stream.sv
// Bench for range_finder_stream. Two instances share one input stream:
// an unsigned CNT_W=8 instance and a signed CNT_W=2 instance (small counter
// so overflow is reachable). A frame-level reference model per instance
// collects each frame's samples and derives the results on completion.
module tb_range_finder_stream;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] data_in = '0;
   logic       data_valid = 1'b0, go = 1'b0, finish = 1'b0;

   logic [7:0]  range_u, min_u, max_u, count_u;
   logic [15:0] sum_u;
   logic        done_u, busy_u, error_u;
   logic [7:0]  range_s, min_s, max_s;
   logic [1:0]  count_s;
   logic [9:0]  sum_s;
   logic        done_s, busy_s, error_s;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clock = ~clock;

   range_finder_stream #(.WIDTH(8), .CNT_W(8), .SIGNED(0)) dut_u (
      .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
      .go(go), .finish(finish), .range(range_u), .min_out(min_u), .max_out(max_u),
      .count(count_u), .sum(sum_u), .done(done_u), .busy(busy_u), .error(error_u));

   range_finder_stream #(.WIDTH(8), .CNT_W(2), .SIGNED(1)) dut_s (
      .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
      .go(go), .finish(finish), .range(range_s), .min_out(min_s), .max_out(max_s),
      .count(count_s), .sum(sum_s), .done(done_s), .busy(busy_s), .error(error_s));

   // Reference model: k=0 unsigned/CNT_W=8, k=1 signed/CNT_W=2.
   // st: 0 idle, 1 frame open, 2 error.
   int st[2], fl[2];
   int fs[2][256];
   int em[2], ex[2], er[2], ec[2], es[2], ed[2];

   function automatic int to_val(input int k, input logic [7:0] d);
      byte b;
      b = d;
      if (k == 1) return int'(b);
      return int'(d);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         st[k] = 0; fl[k] = 0;
         em[k] = 0; ex[k] = 0; er[k] = 0; ec[k] = 0; es[k] = 0; ed[k] = 0;
      end
   endtask

   task automatic publish(input int k);
      int mn, mx, s;
      mn = fs[k][0]; mx = fs[k][0]; s = 0;
      for (int i = 0; i < fl[k]; i++) begin
         if (fs[k][i] < mn) mn = fs[k][i];
         if (fs[k][i] > mx) mx = fs[k][i];
         s += fs[k][i];
      end
      em[k] = mn & 255;
      ex[k] = mx & 255;
      er[k] = (mx - mn) & 255;
      ec[k] = fl[k];
      es[k] = s & ((k == 0) ? 16'hFFFF : 10'h3FF);
      ed[k] = 1;
   endtask

   task automatic model_sample(input int k, input logic g, input logic f, input logic [7:0] d);
      int lim;
      lim = (k == 0) ? 255 : 3;
      case (st[k])
         0: begin
            if (g && !f) begin fl[k] = 1; fs[k][0] = to_val(k, d); st[k] = 1; end
            else if (g && f) begin fl[k] = 1; fs[k][0] = to_val(k, d); publish(k); end
            else if (f) st[k] = 2;
         end
         1: begin
            if (g) st[k] = 2;
            else if (fl[k] == lim) st[k] = 2;
            else begin
               fs[k][fl[k]] = to_val(k, d);
               fl[k]++;
               if (f) begin publish(k); st[k] = 0; end
            end
         end
         default: begin
            if (g && !f) begin fl[k] = 1; fs[k][0] = to_val(k, d); st[k] = 1; end
         end
      endcase
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int exp_sum(input int k);
`ifdef RANGE_FINDER_SUM_EN
      return es[k];
`else
      return 0 * k;
`endif
   endfunction

   task automatic check_all();
      chk("u_min",   32'(min_u),   em[0]);
      chk("u_max",   32'(max_u),   ex[0]);
      chk("u_range", 32'(range_u), er[0]);
      chk("u_count", 32'(count_u), ec[0]);
      chk("u_sum",   32'(sum_u),   exp_sum(0));
      chk("u_done",  32'(done_u),  ed[0]);
      chk("u_busy",  32'(busy_u),  32'(st[0] == 1));
      chk("u_error", 32'(error_u), 32'(st[0] == 2));
      chk("s_min",   32'(min_s),   em[1]);
      chk("s_max",   32'(max_s),   ex[1]);
      chk("s_range", 32'(range_s), er[1]);
      chk("s_count", 32'(count_s), ec[1]);
      chk("s_sum",   32'(sum_s),   exp_sum(1));
      chk("s_done",  32'(done_s),  ed[1]);
      chk("s_busy",  32'(busy_s),  32'(st[1] == 1));
      chk("s_error", 32'(error_s), 32'(st[1] == 2));
   endtask

   // One clock of stimulus: drive, clock, update model, compare.
   task automatic step(input logic v, input logic g, input logic f, input logic [7:0] d);
      data_valid = v; go = g; finish = f; data_in = d;
      @(posedge clock);
      #1;
      ed[0] = 0; ed[1] = 0;
      if (v) begin
         model_sample(0, g, f, d);
         model_sample(1, g, f, d);
      end
      check_all();
      $display("t=%0t v=%0b go=%0b fin=%0b d=%0d | u: min=%0d max=%0d rng=%0d cnt=%0d done=%0b err=%0b | s: min=%0d max=%0d rng=%0d cnt=%0d done=%0b err=%0b",
               $time, v, g, f, d, min_u, max_u, range_u, count_u, done_u, error_u,
               min_s, max_s, range_s, count_s, done_s, error_s);
   endtask

   initial begin
      model_reset();
      #2;
      check_all();
      #5 reset = 1'b0;
      @(negedge clock);

      // Unsigned frame 20,7,200,55
      step(1, 1, 0, 8'd20);
      step(1, 0, 0, 8'd7);
      step(1, 0, 0, 8'd200);
      step(1, 0, 1, 8'd55);
      chk("spec_u_min", 32'(min_u), 7);
      chk("spec_u_max", 32'(max_u), 200);
      chk("spec_u_range", 32'(range_u), 193);
      chk("spec_u_count", 32'(count_u), 4);
      chk("spec_u_done", 32'(done_u), 1);
      step(0, 0, 0, 8'd0);
      chk("spec_done_one_cycle", 32'(done_u), 0);

      // Signed frame -5,3,-100
      step(1, 1, 0, 8'd251);
      step(1, 0, 0, 8'd3);
      step(1, 0, 1, 8'd156);
      chk("spec_s_min", 32'(min_s), 156);
      chk("spec_s_max", 32'(max_s), 3);
      chk("spec_s_range", 32'(range_s), 103);
      chk("spec_s_count", 32'(count_s), 3);

      // Single-sample frame
      step(1, 1, 1, 8'd42);
      chk("spec_single_range", 32'(range_u), 0);
      chk("spec_single_min", 32'(min_u), 42);

      // go mid-frame, then recovery
      step(1, 1, 0, 8'd10);
      step(1, 0, 0, 8'd5);
      step(1, 1, 0, 8'd30);
      chk("spec_abort_error", 32'(error_u), 1);
      chk("spec_abort_hold", 32'(min_u), 42);
      step(1, 1, 0, 8'd9);
      chk("spec_recover_error", 32'(error_u), 0);
      step(1, 0, 0, 8'd4);
      step(1, 0, 1, 8'd11);

      // Overflow on the CNT_W=2 instance, without and with gaps
      step(1, 1, 0, 8'd1);
      step(1, 0, 0, 8'd2);
      step(1, 0, 0, 8'd3);
      step(1, 0, 0, 8'd4);
      chk("spec_overflow", 32'(error_s), 1);
      step(1, 1, 0, 8'd1);
      step(0, 0, 1, 8'd99);
      step(1, 0, 0, 8'd2);
      step(0, 1, 0, 8'd98);
      step(1, 0, 0, 8'd3);
      step(0, 0, 0, 8'd97);
      chk("spec_gap_no_error", 32'(error_s), 0);
      step(1, 0, 0, 8'd4);
      chk("spec_gap_overflow", 32'(error_s), 1);

      // Frame 1,2,3 (sum)
      step(1, 1, 0, 8'd1);
      step(1, 0, 0, 8'd2);
      step(1, 0, 1, 8'd3);

      // Reset mid-frame
      step(1, 1, 0, 8'd50);
      step(1, 0, 0, 8'd60);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_all();
      #1 reset = 1'b0;

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 6) == 0, 8'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
